disp_arbiter: RTL

- Shares the 4-digit seven-segment display between three requesters: account balance (background), transaction amount entry, and timed status messages.
- Converts the selected 8-bit binary value to BCD with a sequential double-dabble engine, which replaces the combinational divide/modulo path.
- Drives a 16-bit digit-code word (4 bits per digit) into the existing multiplexed segment driver.

---
 rtl/disp_pkg.sv | 35 +++
 rtl/bin2bcd_seq.sv | 80 ++++++++
 rtl/disp_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the display arbiter:
//   - digit codes driven to the segment driver (0-9 numerals, E glyph, blank)
//   - grant encodings reported on disp_arbiter.grant
//   - state type of the sequential binary-to-BCD engine
//   - one double-dabble adjust step
// ---------------------------------------------------------------------------
package disp_pkg;

    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_E     = 4'hE;

    localparam logic [1:0] GNT_BAL = 2'd0;
    localparam logic [1:0] GNT_AMT = 2'd1;
    localparam logic [1:0] GNT_MSG = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Add 3 to every BCD nibble that is 5 or more, so that the following
    // left shift carries correctly into the next decimal digit.
    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: 8-bit binary to three BCD digits.
// Sequence: IDLE -(start)-> LOAD (1 cycle) -> SHIFT (8 cycles) -> DONE
// (1 cycle) -> IDLE. busy is high from LOAD through DONE (10 cycles).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (aborts a conversion)
//   start       request; accepted only in IDLE
//   bin[7:0]    value to convert, sampled in LOAD
//   busy        conversion in progress
//   done        high for the single DONE cycle; bcd is valid then
//   bcd[11:0]   {hundreds, tens, ones}
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    state_e      state_q;
    logic [7:0]  sh_q;
    logic [11:0] bcd_q;
    logic [2:0]  cnt_q;
    logic        busy_q;
    logic [11:0] adj;

    assign adj = dd_adjust(bcd_q);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation results that do not match the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    sh_q    <= bin;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    // The binary MSB shifts into the BCD LSB.
                    {bcd_q, sh_q} <= {adj[10:0], sh_q, 1'b0};
                    cnt_q         <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/disp_arbiter.sv
// ---------------------------------------------------------------------------
// disp_arbiter
// Shares the 4-digit seven-segment display between the account balance
// (background), the amount being entered and timed status messages.
// Priority: message > amount (amt_active) > balance.
// Numeric values go through the sequential bin2bcd_seq engine; messages
// bypass it and appear the cycle after msg_req.
// Optional feature (macro LEAD_ZERO_BLANK_EN): leading-zero hundreds/tens
// digits and digit3 are blanked; otherwise digit3 = 0 and leading zeros show.
// Ports:
//   clk, rst_n      100 MHz clock, asynchronous active-low reset
//   bal[7:0]        balance value (source 0)
//   amt[7:0]        amount value (source 1)
//   amt_active      amount entry in progress
//   msg_req         one-cycle message request; msg_code[3:0] sampled with it
//   digits[15:0]    digit codes, [15:12] leftmost ... [3:0] ones
//   grant[1:0]      current owner of the display (GNT_BAL/AMT/MSG)
//   busy            BCD conversion running
//   upd             one-cycle pulse whenever digits changes
// ---------------------------------------------------------------------------
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int HOLD_W      = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  bal,
    input  logic [7:0]  amt,
    input  logic        amt_active,
    input  logic        msg_req,
    input  logic [3:0]  msg_code,
    output logic [15:0] digits,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        upd
);

    // Convert a BCD triple into the 16-bit display word.
    function automatic logic [15:0] fmt_num(input logic [11:0] b);
        logic [3:0] h, t, o;
        h = b[11:8];
        t = b[7:4];
        o = b[3:0];
`ifdef LEAD_ZERO_BLANK_EN
        return {DIG_BLANK,
                (h == 4'd0) ? DIG_BLANK : h,
                (h == 4'd0 && t == 4'd0) ? DIG_BLANK : t,
                o};
`else
        return {4'h0, h, t, o};
`endif
    endfunction

    function automatic logic [15:0] fmt_msg(input logic [3:0] code);
        return {DIG_E, DIG_BLANK, DIG_BLANK, (code > 4'd9) ? DIG_BLANK : code};
    endfunction

`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [15:0] DIGITS_RST = 16'hFFF0;
`else
    localparam logic [15:0] DIGITS_RST = 16'h0000;
`endif

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    // Converter interface
    logic        eng_start;
    logic        eng_busy;
    logic        eng_done;
    logic [11:0] eng_bcd;

    // Numeric source selection (ignores the message)
    logic        src_cur;
    logic [7:0]  val_cur;

    // Registers
    logic              snap_src_q;
    logic [7:0]        snap_val_q;
    logic              load_q;
    logic              msg_act_q, msg_act_d;
    logic [HOLD_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [3:0]        msg_code_q, msg_code_d;
    logic [15:0]       result_q, result_d;
    logic [15:0]       digits_q, digits_d;
    logic [1:0]        grant_q, grant_d;
    logic              upd_q;

    assign src_cur = amt_active;
    assign val_cur = amt_active ? amt : bal;

    // A new conversion starts only from IDLE; changes seen while the engine
    // is busy are picked up by this compare once it returns to IDLE.
    assign eng_start = !eng_busy && ({src_cur, val_cur} != {snap_src_q, snap_val_q});

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (eng_start),
        .bin   (val_cur),
        .busy  (eng_busy),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    // NOTE: every signal assigned in this always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        msg_act_d  = msg_act_q;
        msg_cnt_d  = msg_cnt_q;
        msg_code_d = msg_code_q;
        if (msg_req) begin
            msg_act_d  = 1'b1;
            msg_cnt_d  = HOLD_LOAD;
            msg_code_d = msg_code;
        end else if (msg_act_q) begin
            if (msg_cnt_q == '0) begin
                msg_act_d = 1'b0;
            end else begin
                msg_cnt_d = msg_cnt_q - HOLD_W'(1);
            end
        end

        result_d = eng_done ? fmt_num(eng_bcd) : result_q;
        digits_d = msg_act_d ? fmt_msg(msg_code_d) : result_d;
        grant_d  = msg_act_d ? GNT_MSG : (amt_active ? GNT_AMT : GNT_BAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_src_q <= 1'b0;
            snap_val_q <= '0;
            load_q     <= 1'b0;
            msg_act_q  <= 1'b0;
            msg_cnt_q  <= '0;
            msg_code_q <= '0;
            result_q   <= DIGITS_RST;
            digits_q   <= DIGITS_RST;
            grant_q    <= GNT_BAL;
            upd_q      <= 1'b0;
        end else begin
            // load_q marks the engine's LOAD cycle; the snapshot captures the
            // same value the engine samples on this edge.
            load_q <= eng_start;
            if (load_q) begin
                snap_src_q <= src_cur;
                snap_val_q <= val_cur;
            end
            msg_act_q  <= msg_act_d;
            msg_cnt_q  <= msg_cnt_d;
            msg_code_q <= msg_code_d;
            result_q   <= result_d;
            digits_q   <= digits_d;
            grant_q    <= grant_d;
            upd_q      <= (digits_d != digits_q);
        end
    end

    assign digits = digits_q;
    assign grant  = grant_q;
    assign busy   = eng_busy;
    assign upd    = upd_q;

endmodule
